// File: rtl/nios_flit_mmio_bridge_if.sv
// Avalon-MM slave bus between the Nios II data master and the flit bridge, plus the level interrupt.
interface nios_flit_mmio_bridge_if #(
  parameter int CH_BITS = 1
) ();
  logic [CH_BITS+2:0] address;
  logic               read;
  logic [31:0]        readdata;
  logic               write;
  logic [31:0]        writedata;
  logic               waitrequest;
  logic               irq;

  modport slave (
    input  address, read, write, writedata,
    output readdata, waitrequest, irq
  );

  modport master (
    output address, read, write, writedata,
    input  readdata, waitrequest, irq
  );
endinterface

// File: rtl/nios_flit_mmio_bridge.sv
// Avalon-MM slave fronting NUM_CH flit channels: a 1-entry TX buffer and an RX FIFO per channel.
// Reads return data 1 cycle later; waitrequest stalls only a TXDATA write while that TX buffer is full.
module nios_flit_mmio_bridge #(
  parameter int NUM_CH   = 2,
  parameter int FLIT_W   = 32,
  parameter int RX_DEPTH = 8,
  parameter int CH_BITS  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  nios_flit_mmio_bridge_if.slave   bus,
  output logic [NUM_CH*FLIT_W-1:0] put_flit,
  output logic [NUM_CH-1:0]        en_put,
  input  logic [NUM_CH-1:0]        rdy_put,
  output logic [NUM_CH-1:0]        en_get,
  input  logic [NUM_CH*FLIT_W-1:0] get_flit,
  input  logic [NUM_CH-1:0]        rdy_get
);
  localparam int PW = $clog2(RX_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] REG_STATUS = 3'd0;
  localparam logic [2:0] REG_TXDATA = 3'd1;
  localparam logic [2:0] REG_RXDATA = 3'd2;
  localparam logic [2:0] REG_IRQ_EN = 3'd3;
  localparam logic [2:0] REG_CLEAR  = 3'd4;

  typedef enum logic {TX_EMPTY, TX_FULL} tx_state_t;

  logic [CH_BITS-1:0] ch_sel;
  logic [2:0]         reg_sel;
  logic               ch_ok;
  logic [NUM_CH-1:0]  sel_v;
  logic [NUM_CH-1:0]  wait_ch;
  logic [NUM_CH-1:0]  irq_ch;
  logic [31:0]        rd_word [NUM_CH];
  logic [31:0]        rd_mux;

  assign ch_sel  = bus.address[CH_BITS+2:3];
  assign reg_sel = bus.address[2:0];
  assign ch_ok   = int'(ch_sel) < NUM_CH;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    tx_state_t          tx_state, tx_next;
    logic [FLIT_W-1:0]  tx_buf;
    logic               tx_load, tx_stall, put_en, wr_tx;
    logic [FLIT_W-1:0]  rx_mem [RX_DEPTH];
    logic [PW-1:0]      rx_head, rx_tail;
    logic [CW-1:0]      rx_count;
    logic               push, pop, rd_rx, rx_any, clr;
    logic               underflow, busy_seen;
    logic [2:0]         irq_en;
    logic [31:0]        status, word;

    assign sel_v[c] = ch_ok && (ch_sel == CH_BITS'(c));
    assign wr_tx    = bus.write && sel_v[c] && (reg_sel == REG_TXDATA);
    assign rd_rx    = bus.read  && sel_v[c] && (reg_sel == REG_RXDATA);
    assign clr      = bus.write && sel_v[c] && (reg_sel == REG_CLEAR);
    assign rx_any   = (rx_count != '0);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) tx_state <= TX_EMPTY;
      else     tx_state <= tx_next;
    end

    // A stalled write only lands once the buffer has been observed EMPTY for a cycle.
    always_comb begin
      tx_next  = tx_state;
      tx_load  = 1'b0;
      tx_stall = 1'b0;
      put_en   = 1'b0;
      case (tx_state)
        TX_EMPTY: if (wr_tx) begin
          tx_load = 1'b1;
          tx_next = TX_FULL;
        end
        TX_FULL: begin
          put_en   = rdy_put[c];
          tx_stall = wr_tx;
          if (rdy_put[c]) tx_next = TX_EMPTY;
        end
        default: tx_next = TX_EMPTY;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)          tx_buf <= '0;
      else if (tx_load) tx_buf <= bus.writedata[FLIT_W-1:0];
    end

    assign en_put[c]                    = put_en;
    assign put_flit[c*FLIT_W +: FLIT_W] = tx_buf;
    assign wait_ch[c]                   = tx_stall;

    assign push      = ~rst && rdy_get[c] && (rx_count < CW'(RX_DEPTH));
    assign pop       = rd_rx && rx_any;
    assign en_get[c] = push;

    always_ff @(posedge clk) begin
      if (push) rx_mem[rx_tail] <= get_flit[c*FLIT_W +: FLIT_W];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rx_head  <= '0;
        rx_tail  <= '0;
        rx_count <= '0;
      end else begin
        if (push) rx_tail <= rx_tail + 1'b1;
        if (pop)  rx_head <= rx_head + 1'b1;
        rx_count <= rx_count + CW'(push) - CW'(pop);
      end
    end

    // Setting a sticky flag wins over a CLEAR landing in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        underflow <= 1'b0;
        busy_seen <= 1'b0;
        irq_en    <= '0;
      end else begin
        if (clr && bus.writedata[3]) underflow <= 1'b0;
        if (rd_rx && !rx_any)        underflow <= 1'b1;
        if (clr && bus.writedata[4]) busy_seen <= 1'b0;
        if (tx_stall)                busy_seen <= 1'b1;
        if (bus.write && sel_v[c] && (reg_sel == REG_IRQ_EN)) irq_en <= bus.writedata[2:0];
      end
    end

    assign status = {17'b0, 7'(rx_count), 3'b0, busy_seen, underflow,
                     (rx_count == CW'(RX_DEPTH)), rx_any, (tx_state == TX_EMPTY)};

    always_comb begin
      word = '0;
      case (reg_sel)
        REG_STATUS: word = status;
        REG_RXDATA: word = rx_any ? 32'(rx_mem[rx_head]) : 32'd0;
        REG_IRQ_EN: word = {29'b0, irq_en};
        default:    word = '0;
      endcase
    end

    assign rd_word[c] = word;
    assign irq_ch[c]  = (irq_en[0] && rx_any) || (irq_en[1] && (tx_state == TX_EMPTY)) ||
                        (irq_en[2] && (underflow || busy_seen));
  end

  assign bus.waitrequest = |wait_ch;

  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel_v[c]) rd_mux = rd_word[c];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.readdata <= '0;
      bus.irq      <= 1'b0;
    end else begin
      if (bus.read) bus.readdata <= rd_mux;
      bus.irq <= |irq_ch;
    end
  end
endmodule

// File: tb/tb_nios_flit_mmio_bridge.sv
// Directed bench for nios_flit_mmio_bridge: register table plus TX, RX, interrupt and reset sequences.
module tb_nios_flit_mmio_bridge;
  logic        clk;
  logic        rst;
  logic [63:0] put_flit;
  logic [1:0]  en_put;
  logic [1:0]  rdy_put;
  logic [1:0]  en_get;
  logic [63:0] get_flit;
  logic [1:0]  rdy_get;

  int total = 0;
  int bad   = 0;

  nios_flit_mmio_bridge_if #(.CH_BITS(2)) bus ();

  nios_flit_mmio_bridge #(
    .NUM_CH(2), .FLIT_W(32), .RX_DEPTH(8), .CH_BITS(2)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .put_flit(put_flit), .en_put(en_put), .rdy_put(rdy_put),
    .en_get(en_get), .get_flit(get_flit), .rdy_get(rdy_get)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_rd(input logic [4:0] a, output logic [31:0] d);
    bus.address = a;
    bus.read    = 1'b1;
    @(posedge clk); #1;
    bus.read = 1'b0;
    d = bus.readdata;
  endtask

  task automatic do_wr(input logic [4:0] a, input logic [31:0] d, output int stalls);
    bus.address   = a;
    bus.writedata = d;
    bus.write     = 1'b1;
    stalls        = 0;
    @(negedge clk);
    while (bus.waitrequest && stalls < 40) begin
      stalls++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.write = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int          st;
    int          pushes;
    int          n;
    logic        p;

    vt[0]  = '{1'b0, 5'd0,  32'h0,         32'h1};
    vt[1]  = '{1'b0, 5'd8,  32'h0,         32'h1};
    vt[2]  = '{1'b1, 5'd3,  32'hFFFF_FFF2, 32'h0};
    vt[3]  = '{1'b0, 5'd3,  32'h0,         32'h2};
    vt[4]  = '{1'b1, 5'd3,  32'h0,         32'h0};
    vt[5]  = '{1'b0, 5'd3,  32'h0,         32'h0};
    vt[6]  = '{1'b0, 5'd5,  32'h0,         32'h0};
    vt[7]  = '{1'b0, 5'd15, 32'h0,         32'h0};
    vt[8]  = '{1'b0, 5'd1,  32'h0,         32'h0};
    vt[9]  = '{1'b1, 5'd17, 32'h0000_DEAD, 32'h0};
    vt[10] = '{1'b1, 5'd17, 32'h0000_BEEF, 32'h0};
    vt[11] = '{1'b0, 5'd16, 32'h0,         32'h0};
    vt[12] = '{1'b1, 5'd27, 32'h7,         32'h0};
    vt[13] = '{1'b0, 5'd27, 32'h0,         32'h0};
    vt[14] = '{1'b1, 5'd13, 32'h5,         32'h0};
    vt[15] = '{1'b0, 5'd13, 32'h0,         32'h0};
    vt[16] = '{1'b0, 5'd11, 32'h0,         32'h0};
    vt[17] = '{1'b1, 5'd4,  32'hFFFF_FFFF, 32'h0};
    vt[18] = '{1'b0, 5'd0,  32'h0,         32'h1};

    rst = 1'b0;
    bus.address = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
    rdy_put = '0; rdy_get = 2'b11; get_flit = '0;
    #1 rst = 1'b1;
    #2;
    chk("reset_readdata", bus.readdata, 32'h0);
    chk("reset_wait", 32'(bus.waitrequest), 32'h0);
    chk("reset_irq", 32'(bus.irq), 32'h0);
    chk("reset_en_put", 32'(en_put), 32'h0);
    chk("reset_en_get_rdy_high", 32'(en_get), 32'h0);
    chk("reset_put_flit", put_flit[31:0], 32'h0);
    rdy_get = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("idle_en_get", 32'(en_get), 32'h0);

    for (int i = 0; i < 19; i++) begin
      if (vt[i].wr) begin
        do_wr(vt[i].addr, vt[i].data, st);
        chk($sformatf("vec%0d_stalls", i), st, vt[i].exp);
      end else begin
        do_rd(vt[i].addr, d);
        chk($sformatf("vec%0d_rd", i), d, vt[i].exp);
      end
    end
    chk("table_put_flit", put_flit[31:0], 32'h0);
    chk("table_irq", 32'(bus.irq), 32'h0);

    // TX backpressure on channel 0
    bus.address = 5'd1; bus.writedata = 32'hA5; bus.write = 1'b1;
    @(negedge clk); chk("tx_first_nowait", 32'(bus.waitrequest), 32'h0);
    @(posedge clk); #1; bus.writedata = 32'h5A;
    @(negedge clk);
    chk("tx_second_wait", 32'(bus.waitrequest), 32'h1);
    chk("tx_hold_noput", 32'(en_put[0]), 32'h0);
    chk("tx_hold_flit", put_flit[31:0], 32'hA5);
    @(posedge clk); #1; rdy_put = 2'b01;
    @(negedge clk);
    chk("tx_put_a5_en", 32'(en_put[0]), 32'h1);
    chk("tx_put_a5_flit", put_flit[31:0], 32'hA5);
    chk("tx_put_a5_wait", 32'(bus.waitrequest), 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("tx_empty_wait", 32'(bus.waitrequest), 32'h0);
    chk("tx_empty_noput", 32'(en_put[0]), 32'h0);
    @(posedge clk); #1; bus.write = 1'b0;
    @(negedge clk);
    chk("tx_put_5a_en", 32'(en_put[0]), 32'h1);
    chk("tx_put_5a_flit", put_flit[31:0], 32'h5A);
    @(posedge clk); #1; rdy_put = 2'b00;
    do_rd(5'd0, d); chk("tx_status_busy", d, 32'h11);
    do_wr(5'd4, 32'h10, st);
    do_rd(5'd0, d); chk("tx_status_cleared", d, 32'h01);

    // RX fill to full on channel 1
    rdy_get = 2'b10; n = 1; get_flit[63:32] = 32'(n); pushes = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); p = en_get[1];
      @(posedge clk); #1;
      if (p) begin
        pushes++; n++;
        get_flit[63:32] = 32'(n);
      end
    end
    chk("rx_pushes", pushes, 32'd8);
    chk("rx_en_get_full", 32'(en_get[1]), 32'h0);
    rdy_get = 2'b00;
    do_rd(5'd8, d); chk("rx_status_full", d, 32'h807);
    for (int i = 0; i < 8; i++) begin
      do_rd(5'd10, d); chk($sformatf("rx_pop%0d", i), d, 32'(i + 1));
    end
    do_rd(5'd8, d); chk("rx_status_drained", d, 32'h1);

    // Simultaneous push/pop at count 3, crossing the pointer wrap
    for (int i = 0; i < 3; i++) begin
      get_flit[63:32] = 32'h10 + 32'(i); rdy_get = 2'b10;
      @(posedge clk); #1;
    end
    rdy_get = 2'b00;
    for (int i = 0; i < 6; i++) begin
      bus.address = 5'd10; bus.read = 1'b1;
      rdy_get = 2'b10; get_flit[63:32] = 32'h13 + 32'(i);
      @(negedge clk); chk($sformatf("pp_en_get%0d", i), 32'(en_get[1]), 32'h1);
      @(posedge clk); #1;
      chk($sformatf("pp_data%0d", i), bus.readdata, 32'h10 + 32'(i));
    end
    bus.read = 1'b0; rdy_get = 2'b00;
    do_rd(5'd8, d); chk("pp_count3", d, 32'h303);
    for (int i = 0; i < 3; i++) begin
      do_rd(5'd10, d); chk($sformatf("pp_tail%0d", i), d, 32'h16 + 32'(i));
    end
    do_rd(5'd8, d); chk("pp_empty", d, 32'h1);

    // Underflow and the error interrupt
    do_wr(5'd11, 32'h4, st);
    chk("uf_irq_before", 32'(bus.irq), 32'h0);
    do_rd(5'd10, d); chk("uf_data", d, 32'h0);
    chk("uf_irq_same_cycle", 32'(bus.irq), 32'h0);
    @(posedge clk); #1; chk("uf_irq_next", 32'(bus.irq), 32'h1);
    do_rd(5'd8, d); chk("uf_status", d, 32'h9);
    do_wr(5'd12, 32'h8, st);
    @(posedge clk); #1; chk("uf_irq_cleared", 32'(bus.irq), 32'h0);
    do_wr(5'd11, 32'h0, st);

    // RX-nonempty interrupt on channel 0
    do_wr(5'd3, 32'h1, st);
    rdy_get = 2'b01; get_flit[31:0] = 32'h77;
    @(posedge clk); #1; rdy_get = 2'b00;
    chk("irq_at_push", 32'(bus.irq), 32'h0);
    @(posedge clk); #1; chk("irq_after_push", 32'(bus.irq), 32'h1);
    do_rd(5'd2, d); chk("irq_pop_data", d, 32'h77);
    @(posedge clk); #1; chk("irq_after_pop", 32'(bus.irq), 32'h0);

    // Reset mid-transfer
    rdy_put = 2'b00;
    do_wr(5'd1, 32'h33, st);
    rdy_get = 2'b10; get_flit[63:32] = 32'h44;
    @(posedge clk); #1; rdy_get = 2'b00;
    rdy_put = 2'b01;
    #1; chk("mid_en_put_before", 32'(en_put[0]), 32'h1);
    do_rd(5'd2, d);
    rst = 1'b1; #1;
    chk("mid_en_put", 32'(en_put), 32'h0);
    chk("mid_put_flit", put_flit[31:0], 32'h0);
    chk("mid_readdata", bus.readdata, 32'h0);
    rdy_put = 2'b00;
    @(posedge clk); #1; rst = 1'b0;
    do_rd(5'd0, d); chk("mid_status_ch0", d, 32'h1);
    do_rd(5'd8, d); chk("mid_status_ch1", d, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
